// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit qualified start, LSB-first data, optional parity, one stop bit.
// Latency: rx_valid one clk after the tick that samples mid stop bit (+2 clk line synchronizer).
// Backpressure: none; rx_valid is a one-clk pulse and must be consumed on that cycle.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    state_t               state, state_next;
    logic [3:0]           tick_cnt, cnt_next;
    logic [2:0]           bit_idx, idx_next;
    logic                 rx_meta, rx_s;
    logic [DATA_BITS-1:0] shreg;
    logic                 data_xor;
    logic                 par_err_next;
    logic                 cfg_par_en, cfg_par_odd;
    logic                 wait_high;
    logic                 start_frame, shift_en, par_sample, deliver;

    // Two-flop synchronizer; resets high so the idle line never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame sequencing state, oversample counter and bit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
        end else begin
            state    <= state_next;
            tick_cnt <= cnt_next;
            bit_idx  <= idx_next;
        end
    end

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_next  = state;
        cnt_next    = tick_cnt;
        idx_next    = bit_idx;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        deliver     = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    // A line still low from a broken frame must go high before a new start counts.
                    if (!rx_s && !wait_high) begin
                        state_next  = S_START;
                        cnt_next    = 4'd0;
                        start_frame = 1'b1;
                    end
                end
                S_START: begin
                    cnt_next = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd7) begin
                        cnt_next = 4'd0;
                        if (!rx_s) begin
                            state_next = S_DATA;
                            idx_next   = 3'd0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    cnt_next = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_en = 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            state_next = cfg_par_en ? S_PARITY : S_STOP;
                        end else begin
                            idx_next = bit_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_next = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        par_sample = 1'b1;
                        state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_next = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        deliver    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: frame config latch, shift register, running parity and delivered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_par_en   <= 1'b0;
            cfg_par_odd  <= 1'b0;
            shreg        <= '0;
            data_xor     <= 1'b0;
            par_err_next <= 1'b0;
            wait_high    <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            rx_valid <= deliver;
            if (start_frame) begin
                cfg_par_en   <= parity_en;
                cfg_par_odd  <= parity_odd;
                data_xor     <= 1'b0;
                par_err_next <= 1'b0;
            end
            if (shift_en) begin
                shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                data_xor <= data_xor ^ rx_s;
            end
            if (par_sample) begin
                par_err_next <= rx_s ^ data_xor ^ cfg_par_odd;
            end
            if (deliver) begin
                rx_data    <= shreg;
                frame_err  <= ~rx_s;
                parity_err <= cfg_par_en & par_err_next;
                wait_high  <= ~rx_s;
            end else if (tick && state == S_IDLE && rx_s) begin
                wait_high <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: randomized frames checked against a bit-level line model.
// Tick every 4 clks, so one bit time is 64 clks.
// Received characters are collected by a monitor and compared per scenario.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       rx;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_data[$];
    logic       q_fe[$];
    logic       q_pe[$];
    int         wide_cnt = 0;
    logic       prev_vld = 1'b0;

    uart_rx #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clk high out of every four.
    initial begin
        int tc;
        tc   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tc   = (tc + 1) % 4;
            tick = (tc == 0);
        end
    end

    // Collect every delivered character; also count pulses longer than one clk.
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            q_data.push_back(rx_data);
            q_fe.push_back(frame_err);
            q_pe.push_back(parity_err);
            if (prev_vld) wide_cnt++;
        end
        prev_vld = (rx_valid === 1'b1);
    end

    function automatic logic exp_perr(input logic [7:0] d, input logic odd, input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_fe.delete();
        q_pe.delete();
    endtask

    // Build the line waveform for one character and drive it bit by bit.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stop);
        foreach (bits[i]) begin
            rx = bits[i];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clks(3);
        checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b1;
        wait_clks(40);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
        checks++; if (q_data.size() !== 0) begin errors++; $display("FAIL reset_no_frame got %0d want 0", q_data.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] vals[4];
        logic [7:0] got;
        vals[0] = 8'hA5;
        for (int i = 1; i < 4; i++) vals[i] = 8'($urandom_range(0, 255));
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clear_q();
            send_frame(vals[i], 1'b0, 1'b0, 1'b1);
            wait_clks(16);
            checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL basic_count[%0d] got %0d want 1", i, q_data.size()); end
            if (q_data.size() > 0) begin
                got = q_data.pop_front();
                checks++; if (got !== vals[i])          begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got, vals[i]); end
                checks++; if (q_fe.pop_front() !== 1'b0) begin errors++; $display("FAIL basic_frame_err[%0d] got 1 want 0", i); end
                checks++; if (q_pe.pop_front() !== 1'b0) begin errors++; $display("FAIL basic_parity_err[%0d] got 1 want 0", i); end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy[%0d] got %b want 0", i, busy); end
        end
    endtask

    task automatic test_parity();
        logic [7:0] d[7];
        logic       odd[7];
        logic       pb[7];
        logic       exp;
        logic       got;
        d[0] = 8'h3C; odd[0] = 1'b0; pb[0] = 1'b0;
        d[1] = 8'h3C; odd[1] = 1'b0; pb[1] = 1'b1;
        d[2] = 8'h3C; odd[2] = 1'b1; pb[2] = 1'b1;
        for (int i = 3; i < 7; i++) begin
            d[i]   = 8'($urandom_range(0, 255));
            odd[i] = 1'($urandom_range(0, 1));
            pb[i]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 7; i++) begin
            clear_q();
            parity_en  = 1'b1;
            parity_odd = odd[i];
            exp = exp_perr(d[i], odd[i], pb[i]);
            fork
                send_frame(d[i], 1'b1, pb[i], 1'b1);
                begin
                    // Configuration changes after the start bit must not affect this frame.
                    wait_clks(2 * BIT_CLKS);
                    parity_odd = ~odd[i];
                    parity_en  = 1'b0;
                end
            join
            wait_clks(16);
            checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL parity_count[%0d] got %0d want 1", i, q_data.size()); end
            if (q_data.size() > 0) begin
                got = q_pe.pop_front();
                checks++; if (got !== exp)                  begin errors++; $display("FAIL parity_err[%0d] got %b want %b", i, got, exp); end
                checks++; if (q_data.pop_front() !== d[i])  begin errors++; $display("FAIL parity_data[%0d] want %h", i, d[i]); end
            end
        end
        parity_en  = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_frame_err();
        logic [7:0] nxt;
        clear_q();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        wait_clks(3 * BIT_CLKS);
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL break_count got %0d want 1", q_data.size()); end
        if (q_data.size() > 0) begin
            checks++; if (q_data[0] !== 8'h55) begin errors++; $display("FAIL break_data got %h want 55", q_data[0]); end
            checks++; if (q_fe[0] !== 1'b1)    begin errors++; $display("FAIL break_frame_err got %b want 1", q_fe[0]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b want 0", busy); end
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        clear_q();
        nxt = 8'($urandom_range(0, 255));
        send_frame(nxt, 1'b0, 1'b0, 1'b1);
        wait_clks(16);
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL after_break_count got %0d want 1", q_data.size()); end
        if (q_data.size() > 0) begin
            checks++; if (q_data[0] !== nxt) begin errors++; $display("FAIL after_break_data got %h want %h", q_data[0], nxt); end
            checks++; if (q_fe[0] !== 1'b0)  begin errors++; $display("FAIL after_break_frame_err got %b want 0", q_fe[0]); end
        end
    endtask

    task automatic test_false_start();
        clear_q();
        rx = 1'b0;
        wait_clks(16);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_high got %b want 1", busy); end
        wait_clks(4);
        rx = 1'b1;
        wait_clks(12 * BIT_CLKS);
        checks++; if (q_data.size() !== 0) begin errors++; $display("FAIL false_start_pulse got %0d want 0", q_data.size()); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL false_start_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[4];
        vals[0] = 8'h12;
        vals[1] = 8'hEF;
        vals[2] = 8'($urandom_range(0, 255));
        vals[3] = 8'($urandom_range(0, 255));
        clear_q();
        wide_cnt = 0;
        for (int i = 0; i < 4; i++) send_frame(vals[i], 1'b0, 1'b0, 1'b1);
        wait_clks(16);
        checks++; if (q_data.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (q_data.size() > 0) begin
                checks++; if (q_data[0] !== vals[i])          begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, q_data[0], vals[i]); end
                checks++; if (q_fe[0] !== 1'b0 || q_pe[0] !== 1'b0) begin errors++; $display("FAIL b2b_flags[%0d] got fe=%b pe=%b want 0", i, q_fe[0], q_pe[0]); end
                void'(q_data.pop_front());
                void'(q_fe.pop_front());
                void'(q_pe.pop_front());
            end
        end
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL valid_width got %0d long pulses want 0", wide_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        clear_q();
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = d[3];
        wait_clks(BIT_CLKS / 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", busy); end
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL midreset_outputs got data=%h vld=%b fe=%b pe=%b busy=%b want all 0", rx_data, rx_valid, frame_err, parity_err, busy); end
        reset = 1'b1;
        wait_clks(8 * BIT_CLKS);
        checks++; if (q_data.size() !== 0) begin errors++; $display("FAIL midreset_no_pulse got %0d want 0", q_data.size()); end
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        wait_clks(16);
        checks++; if (q_data.size() !== 1) begin errors++; $display("FAIL midreset_after_count got %0d want 1", q_data.size()); end
        if (q_data.size() > 0) begin
            checks++; if (q_data[0] !== 8'h7E) begin errors++; $display("FAIL midreset_after_data got %h want 7e", q_data[0]); end
        end
    endtask

    initial begin
        reset      = 1'b0;
        rx         = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
